ctr_seq: RTL and testbench

CTR_SEQ -- requirements
Module: ctr_seq

---
 rtl/ctr_seq.sv | 136 +++++++++++++
 tb/tb_ctr_seq.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ctr_seq.sv
`default_nettype none
// ============================================================================
//  Module   : ctr_seq
//  Brief    : Measurement sequencer for a counter stage (clear, arm, gate,
//             stop, latch) with acknowledge timeouts.
//  Revision : 1.0 - initial release
// ============================================================================
module ctr_seq #(
    parameter int size = 8,
    parameter int gw   = 16,
    parameter int tmo  = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [gw-1:0]   gate,
    output logic            clr,
    output logic            brq,
    output logic            erq,
    input  logic            bac,
    input  logic            eac,
    input  logic [size-1:0] cnx,
    input  logic [size-1:0] cnr,
    output logic [size-1:0] resx,
    output logic [size-1:0] resr,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int c_TW = (tmo < 2) ? 1 : $clog2(tmo + 1);
    // Last cycle index in ARM/STOP before the timeout counter would reach tmo.
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(tmo - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_CLEAR = 3'd1;
    localparam logic [2:0] c_ST_ARM   = 3'd2;
    localparam logic [2:0] c_ST_GATE  = 3'd3;
    localparam logic [2:0] c_ST_STOP  = 3'd4;
    localparam logic [2:0] c_ST_LATCH = 3'd5;
    localparam logic [2:0] c_ST_DONE  = 3'd6;

    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic [gw-1:0]   r_gate;
    logic [gw-1:0]   r_gcnt;
    logic [c_TW-1:0] r_tcnt;
    logic            w_tmo_hit;
    logic            w_abort;

    always_comb begin
        w_next    = r_state;
        w_tmo_hit = (r_tcnt == c_TMO_LAST);
        w_abort   = 1'b0;
        case (r_state)
            c_ST_IDLE:  if (start) w_next = c_ST_CLEAR;
            c_ST_CLEAR: w_next = c_ST_ARM;
            c_ST_ARM: begin
                // An acknowledge in the final timeout cycle still wins.
                if (bac) begin
                    w_next = c_ST_GATE;
                end else if (w_tmo_hit) begin
                    w_next  = c_ST_DONE;
                    w_abort = 1'b1;
                end
            end
            c_ST_GATE:  if (r_gcnt <= gw'(1)) w_next = c_ST_STOP;
            c_ST_STOP: begin
                if (eac) begin
                    w_next = c_ST_LATCH;
                end else if (w_tmo_hit) begin
                    w_next  = c_ST_DONE;
                    w_abort = 1'b1;
                end
            end
            c_ST_LATCH: w_next = c_ST_DONE;
            c_ST_DONE:  w_next = c_ST_IDLE;
            default:    w_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_gate  <= '0;
            r_gcnt  <= '0;
            r_tcnt  <= '0;
            clr     <= 1'b1;
            brq     <= 1'b0;
            erq     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            resx    <= '0;
            resr    <= '0;
        end else begin
            r_state <= w_next;

            // Outputs are decoded from the state being entered so they line up with it.
            clr  <= (w_next == c_ST_IDLE) || (w_next == c_ST_CLEAR);
            brq  <= (w_next == c_ST_ARM)  || (w_next == c_ST_GATE) ||
                    (w_next == c_ST_STOP) || (w_next == c_ST_LATCH);
            erq  <= (w_next == c_ST_STOP) || (w_next == c_ST_LATCH);
            busy <= (w_next != c_ST_IDLE);
            done <= (w_next == c_ST_DONE);

            if (r_state == c_ST_IDLE && start) begin
                r_gate <= gate;
                err    <= 1'b0;
            end
            if (w_abort) begin
                err <= 1'b1;
            end

            if ((w_next != r_state) && ((w_next == c_ST_ARM) || (w_next == c_ST_STOP))) begin
                r_tcnt <= '0;
            end else if ((r_state == c_ST_ARM) || (r_state == c_ST_STOP)) begin
                r_tcnt <= r_tcnt + c_TW'(1);
            end

            // A zero gate is run as a single cycle.
            if ((w_next == c_ST_GATE) && (r_state != c_ST_GATE)) begin
                r_gcnt <= (r_gate == '0) ? gw'(1) : r_gate;
            end else if ((r_state == c_ST_GATE) && (r_gcnt != '0)) begin
                r_gcnt <= r_gcnt - gw'(1);
            end

            if (r_state == c_ST_LATCH) begin
                resx <= cnx;
                resr <= cnr;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ctr_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ctr_seq
//  Brief    : Self-checking bench for ctr_seq using a timeline reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ctr_seq;

    localparam int SIZE = 8;
    localparam int GW   = 16;
    localparam int TMO  = 255;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [GW-1:0]   gate;
    logic            clr, brq, erq, bac, eac, busy, done, err;
    logic [SIZE-1:0] cnx, cnr, resx, resr;

    int n_checks = 0;
    int n_errors = 0;

    logic            exp_err;
    logic [SIZE-1:0] exp_x, exp_r;

    ctr_seq #(.size(SIZE), .gw(GW), .tmo(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .gate(gate),
        .clr(clr), .brq(brq), .erq(erq), .bac(bac), .eac(eac),
        .cnx(cnx), .cnr(cnr), .resx(resx), .resr(resr),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_res();
        check("resx", 32'(resx), 32'(exp_x));
        check("resr", 32'(resr), 32'(exp_r));
    endtask

    // Idle cycles: outputs must show IDLE; bac/eac noise must be ignored.
    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            check("idle", {26'd0, clr, brq, erq, busy, done, err},
                  {26'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, exp_err});
            check_res();
            rst   = 1'b0;
            start = 1'b0;
            gate  = GW'($urandom);
            bac   = 1'($urandom);
            eac   = 1'($urandom);
            cnx   = SIZE'($urandom);
            cnr   = SIZE'($urandom);
        end
    endtask

    // One measurement, modelled as a timeline of phase lengths.
    // Cycle 0 is the IDLE cycle in which start is accepted.
    // db/de: acknowledge delay in cycles after ARM/STOP entry (>= TMO means never).
    task automatic run_meas(input int g, input int db, input int de, input bit hold,
                            input bit rst_in_stop, input int fx, input int fr);
        int  la, lg, ls, s0, t_latch, t_done, rst_at;
        bit  ab_a, ab_e, abort;
        bit  e_clr, e_brq, e_erq, e_busy, e_done, e_err;
        ab_a    = (db >= TMO);
        la      = ab_a ? TMO : db + 1;
        lg      = (g == 0) ? 1 : g;
        ab_e    = (de >= TMO);
        ls      = ab_e ? TMO : de + 1;
        s0      = ab_a ? 1 << 30 : 2 + la + lg;
        abort   = ab_a || ab_e;
        t_latch = ab_a ? -1 : (ab_e ? -1 : s0 + ls);
        t_done  = ab_a ? 2 + la : (ab_e ? s0 + ls : t_latch + 1);
        rst_at  = rst_in_stop ? s0 + 1 : -1;
        for (int n = 0; n <= t_done; n++) begin
            @(negedge clk);
            e_clr  = (n <= 1);
            e_busy = (n >= 1);
            e_brq  = (n >= 2) && (n < t_done);
            e_erq  = (n >= s0) && (n < t_done);
            e_done = (n == t_done);
            e_err  = (n == 0) ? exp_err : ((n == t_done) ? abort : 1'b0);
            check("outs", {26'd0, clr, brq, erq, busy, done, err},
                  {26'd0, e_clr, e_brq, e_erq, e_busy, e_done, e_err});
            check_res();
            start = (n == 0) ? 1'b1 : ((n == t_done) ? hold : 1'($urandom));
            gate  = (n == 0) ? GW'(g) : GW'($urandom);
            bac   = (n >= 2 + db) || ((n < 2) && 1'($urandom));
            eac   = (!ab_a && (n >= s0 + de)) || ((n < s0) && 1'($urandom));
            cnx   = SIZE'($urandom);
            cnr   = SIZE'($urandom);
            rst   = (n == rst_at);
            if (n == t_latch) begin
                if (fx >= 0) cnx = SIZE'(fx);
                if (fr >= 0) cnr = SIZE'(fr);
                exp_x = cnx;
                exp_r = cnr;
            end
            if (n == rst_at) begin
                exp_err = 1'b0;
                exp_x   = '0;
                exp_r   = '0;
                return;
            end
        end
        exp_err = abort;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; gate = '0; bac = 1'b0; eac = 1'b0;
        cnx = '0; cnr = '0;
        exp_err = 1'b0; exp_x = '0; exp_r = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_outs", {26'd0, clr, brq, erq, busy, done, err}, {26'd0, 6'b100000});
        check_res();
        idle_cycles(3);

        run_meas(10, 3, 2, 1'b0, 1'b0, 'h2A, 'h7F);
        idle_cycles(2);
        run_meas(0, 0, 0, 1'b0, 1'b0, -1, -1);
        idle_cycles(2);
        run_meas(5, 1000, 0, 1'b0, 1'b0, -1, -1);
        idle_cycles(2);
        run_meas(4, 2, 1000, 1'b0, 1'b0, -1, -1);
        idle_cycles(2);
        run_meas(3, TMO - 1, TMO - 1, 1'b0, 1'b0, -1, -1);
        idle_cycles(1);
        run_meas(3, TMO, 0, 1'b0, 1'b0, -1, -1);
        idle_cycles(1);
        run_meas(1, 1, 1, 1'b1, 1'b0, -1, -1);
        run_meas(2, 0, 0, 1'b0, 1'b0, -1, -1);
        idle_cycles(1);
        run_meas(6, 2, 3, 1'b0, 1'b1, -1, -1);
        idle_cycles(3);

        for (int k = 0; k < 20; k++) begin
            int  g, db, de;
            bit  hold;
            g    = $urandom_range(0, 12);
            db   = ($urandom_range(0, 9) == 0) ? TMO + $urandom_range(0, 3) : $urandom_range(0, 5);
            de   = ($urandom_range(0, 9) == 0) ? TMO + $urandom_range(0, 3) : $urandom_range(0, 5);
            hold = 1'($urandom);
            run_meas(g, db, de, hold, 1'b0, -1, -1);
            if (!hold) idle_cycles($urandom_range(0, 2));
        end
        idle_cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
